pulse_1s_gen: RTL and testbench
===============================

# pulse_1s_gen

Free-running one-second tick generator for the DHTK clock design. It divides the system clock `clk` down to a periodic strobe `pulse` that drives downstream second, minute and hour counters. It also keeps a local 0–59 seconds count and flags each minute rollover. It has no data inputs: after reset it runs indefinitely.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: input clock frequency; the divide ratio DIV = CLK_FREQ_HZ in normal builds.
- `SIM_DIV`, default 10: divide ratio used when the fast-simulation macro is defined.
- `PULSE_WIDTH`, default 1: `pulse` high time in clk cycles.
  - Legal range is 1 to DIV-1.
  - Out-of-range values or DIV < 2 are an elaboration error (`$error`).

Ports:
- `clk`, input, 1 bit: single system clock; all logic on the rising edge.
- `rst_p`, input, 1 bit: reset. Synchronous, active-high.
- `pulse`, output, 1 bit: one-second strobe, registered.
- `sec_cnt`, output, 6 bits: seconds elapsed, range 0..59, registered.
- `min_tick`, output, 1 bit: high for one cycle on each 59→0 wrap of `sec_cnt`, registered.

## Operation
- Internal divider `div_cnt` has width $clog2(DIV).
  - It counts 0, 1, …, DIV-1, then returns to 0, advancing one step per rising edge of `clk`.
- Terminal condition: `div_cnt == DIV-1`. On the edge where `div_cnt` is at terminal:
  - `div_cnt` <= 0.
  - `pulse` <= 1.
  - `sec_cnt` <= `sec_cnt`+1, or 0 if it was 59.
  - `min_tick` <= 1 if `sec_cnt` was 59, otherwise 0.
- `pulse` stays high for PULSE_WIDTH cycles, then drops to 0.
  - The width is tracked by a small down-counter.
  - `pulse` is never high across a terminal event, because PULSE_WIDTH < DIV.
- `min_tick` is always exactly 1 cycle wide, whatever PULSE_WIDTH is. It rises on the same edge as the `pulse` that wraps `sec_cnt`.
- `sec_cnt` never holds 60..63.
- Reset, applied whenever `rst_p` is sampled high at a rising edge:
  - `div_cnt` = 0.
  - `pulse` = 0.
  - `sec_cnt` = 0.
  - `min_tick` = 0.
  - The pulse-width counter = 0.
- Reset overrides a coincident terminal event. A partially elapsed period is discarded.

## Timing
- All outputs are registered. There are no combinational paths from `rst_p` to the outputs, other than through the clock edge.
- First pulse: let edge 0 be the first rising edge with `rst_p` low after reset.
  - `pulse` rises after edge DIV-1, i.e. on the DIV-th rising edge after reset release.
  - It is high for PULSE_WIDTH cycles.
- After the first pulse, rising edges of `pulse` are exactly DIV cycles apart, with no drift.
- `sec_cnt` changes on the same edge that `pulse` rises.
- `min_tick` first rises on the 60th `pulse` after reset, i.e. 60·DIV cycles after release.
- If `rst_p` is held high across multiple edges, all outputs stay 0 for that whole time.

## Configuration
- Macro `PULSE_1S_FAST_SIM_EN`.
  - Defined: DIV = SIM_DIV. `CLK_FREQ_HZ` is ignored, so a full second takes a few clocks in simulation.
  - Undefined (the synthesis default): DIV = CLK_FREQ_HZ.
- No other behaviour differs between the two builds.

## Test plan
All scenarios use `PULSE_1S_FAST_SIM_EN` with SIM_DIV=10.
- Reset: hold `rst_p`=1 for 2 cycles → `pulse`=0, `sec_cnt`=0, `min_tick`=0, throughout and on the first edge after release.
- First tick: release reset at edge 0 → `pulse` rises exactly 10 edges later, is high 1 cycle, and `sec_cnt`=1.
- Period: run for 50 cycles → `pulse` rising edges are spaced exactly 10 cycles apart and `sec_cnt` reaches 5.
- Minute wrap: run for 600 cycles → on the 60th pulse, `sec_cnt` goes 59→0 and `min_tick`=1 for exactly that one cycle.
- Mid-count reset: assert `rst_p` for 1 cycle at cycle 7 of a period → outputs go to 0, and the next `pulse` arrives 10 edges after release, not 3.
- Width: rebuild with PULSE_WIDTH=3 → `pulse` is high 3 cycles out of every 10, and `min_tick` is still 1 cycle wide.

Source files
------------

// File: rtl/pulse_1s_gen.sv
// One-second strobe generator: divides clk by DIV, keeps a 0..59 seconds count and flags minute wraps.
// Build macro PULSE_1S_FAST_SIM_EN selects DIV = SIM_DIV instead of CLK_FREQ_HZ.
module pulse_1s_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SIM_DIV     = 10,
    parameter int PULSE_WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_p,
    output logic       pulse,
    output logic [5:0] sec_cnt,
    output logic       min_tick
);

`ifdef PULSE_1S_FAST_SIM_EN
    localparam int DIV = SIM_DIV;
`else
    localparam int DIV = CLK_FREQ_HZ;
`endif

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    // PULSE_WIDTH < DIV, so the width counter fits in the divider width
    localparam logic [CW-1:0] PW_LOAD  = CW'(PULSE_WIDTH - 1);

    generate
        if (DIV < 2 || PULSE_WIDTH < 1 || PULSE_WIDTH > DIV - 1) begin : g_bad_cfg
            $error("pulse_1s_gen: illegal configuration DIV=%0d PULSE_WIDTH=%0d", DIV, PULSE_WIDTH);
        end
    endgenerate

    logic [CW-1:0] div_cnt_reg, div_cnt_next;
    logic [CW-1:0] pw_cnt_reg,  pw_cnt_next;
    logic          pulse_reg,   pulse_next;
    logic [5:0]    sec_cnt_reg, sec_cnt_next;
    logic          min_tick_reg, min_tick_next;
    logic          terminal;

    always_comb begin
        terminal      = (div_cnt_reg == DIV_LAST);
        div_cnt_next  = div_cnt_reg + 1'b1;
        pw_cnt_next   = pw_cnt_reg;
        pulse_next    = 1'b0;
        sec_cnt_next  = sec_cnt_reg;
        min_tick_next = 1'b0;
        if (terminal) begin
            div_cnt_next  = '0;
            pulse_next    = 1'b1;
            pw_cnt_next   = PW_LOAD;
            sec_cnt_next  = (sec_cnt_reg == 6'd59) ? 6'd0 : sec_cnt_reg + 6'd1;
            min_tick_next = (sec_cnt_reg == 6'd59);
        end else if (pw_cnt_reg != '0) begin
            // remaining high cycles of a multi-cycle strobe
            pw_cnt_next = pw_cnt_reg - 1'b1;
            pulse_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            div_cnt_reg  <= '0;
            pw_cnt_reg   <= '0;
            pulse_reg    <= 1'b0;
            sec_cnt_reg  <= 6'd0;
            min_tick_reg <= 1'b0;
        end else begin
            div_cnt_reg  <= div_cnt_next;
            pw_cnt_reg   <= pw_cnt_next;
            pulse_reg    <= pulse_next;
            sec_cnt_reg  <= sec_cnt_next;
            min_tick_reg <= min_tick_next;
        end
    end

    assign pulse    = pulse_reg;
    assign sec_cnt  = sec_cnt_reg;
    assign min_tick = min_tick_reg;

endmodule

// File: tb/tb_pulse_1s_gen.sv
// Directed bench for pulse_1s_gen with DIV = 10 in both builds; a width-1 and a width-3 instance run side by side.
module tb_pulse_1s_gen;

    logic       clk = 1'b0;
    logic       rst_p = 1'b1;
    logic       pulse1, pulse3;
    logic [5:0] sec1, sec3;
    logic       min1, min3;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;              // rising edges since reset release
    logic prev_pulse = 1'b0;

    typedef struct {
        logic       p1;
        logic       p3;
        logic [5:0] s;
        logic       m;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pulse_1s_gen #(.CLK_FREQ_HZ(10), .SIM_DIV(10), .PULSE_WIDTH(1)) dut1 (
        .clk(clk), .rst_p(rst_p), .pulse(pulse1), .sec_cnt(sec1), .min_tick(min1)
    );

    pulse_1s_gen #(.CLK_FREQ_HZ(10), .SIM_DIV(10), .PULSE_WIDTH(3)) dut3 (
        .clk(clk), .rst_p(rst_p), .pulse(pulse3), .sec_cnt(sec3), .min_tick(min3)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // One clock: drive reset, push the expectation for the state after the edge, then pop and compare.
    task automatic step(input logic r);
        exp_t e;
        rst_p = r;
        if (r) begin
            n = 0;
            e = '{p1: 1'b0, p3: 1'b0, s: 6'd0, m: 1'b0};
        end else begin
            n++;
            e.p1 = (n >= 10) && ((n % 10) < 1);
            e.p3 = (n >= 10) && ((n % 10) < 3);
            e.s  = 6'((n / 10) % 60);
            e.m  = (n >= 600) && ((n % 600) == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pulse_w1",    {7'd0, pulse1}, {7'd0, e.p1});
        chk("sec_cnt_w1",  {2'd0, sec1},   {2'd0, e.s});
        chk("min_tick_w1", {7'd0, min1},   {7'd0, e.m});
        chk("pulse_w3",    {7'd0, pulse3}, {7'd0, e.p3});
        chk("sec_cnt_w3",  {2'd0, sec3},   {2'd0, e.s});
        chk("min_tick_w3", {7'd0, min3},   {7'd0, e.m});
        if (pulse1 && !prev_pulse)
            $display("tick n=%0d sec_cnt=%0d min_tick=%0b rst_p=%0b", n, sec1, min1, r);
        prev_pulse = pulse1;
    endtask

    initial begin
        // reset held for two edges
        step(1'b1);
        step(1'b1);
        // first tick, steady period, minute wrap and beyond
        for (int i = 0; i < 650; i++) step(1'b0);
        // walk to cycle 7 of a period, then a one-cycle reset
        while ((n % 10) != 7) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 35; i++) step(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
